// File: rtl/iobus_pkg.sv
// rtl/iobus_pkg.sv - shared widths, flattened-vector helpers and nodev FSM states for the IO bus connector
package iobus_pkg;

  localparam int IOS_W  = 7;
  localparam int DATA_W = 36;
  localparam int PI_W   = 7;

  // Widths of the flattened per-slave vectors (slave k occupies slice [k*W +: W])
  function automatic int ios_vec_w(input int nslave);
    return nslave * IOS_W;
  endfunction

  function automatic int data_vec_w(input int nslave);
    return nslave * DATA_W;
  endfunction

  function automatic int pi_vec_w(input int nslave);
    return nslave * PI_W;
  endfunction

  typedef enum logic {
    NODEV_IDLE = 1'b0,
    NODEV_FLAG = 1'b1
  } nodev_state_e;

endpackage

// File: rtl/iobus_dev_decode.sv
// rtl/iobus_dev_decode.sv - device-code comparator producing one slave select
module iobus_dev_decode
  import iobus_pkg::*;
#(
  parameter logic [IOS_W-1:0] DEVCODE = '0
) (
  input  logic [IOS_W-1:0] m_ios_i,
  output logic             sel_o
);

  assign sel_o = (m_ios_i == DEVCODE);

endmodule

// File: rtl/iobus_n_connect.sv
// rtl/iobus_n_connect.sv - N-slave IO bus connector; optional transfer counter under IOBUS_XFER_CNT_EN
module iobus_n_connect
  import iobus_pkg::*;
#(
  parameter int                         NSLAVE   = 2,
  // slave 0 answers 7'o070, slave 1 answers 7'o024
  parameter logic [NSLAVE*IOS_W-1:0]    DEVCODES = {7'o024, 7'o070}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          m_iob_poweron,
  input  logic                          m_iob_reset,
  input  logic                          m_datao_clear,
  input  logic                          m_datao_set,
  input  logic                          m_cono_clear,
  input  logic                          m_cono_set,
  input  logic                          m_iob_fm_datai,
  input  logic                          m_iob_fm_status,
  input  logic                          m_rdi_pulse,
  input  logic [IOS_W-1:0]              m_ios,
  input  logic [DATA_W-1:0]             m_iob_write,
  output logic [PI_W-1:0]               m_pi_req,
  output logic [DATA_W-1:0]             m_iob_read,
  output logic                          m_dr_split,
  output logic                          m_rdi_data,
  output logic                          m_nodev,
  output logic [NSLAVE-1:0]             s_iob_poweron,
  output logic [NSLAVE-1:0]             s_iob_reset,
  output logic [NSLAVE-1:0]             s_rdi_pulse,
  output logic [NSLAVE-1:0]             s_datao_clear,
  output logic [NSLAVE-1:0]             s_datao_set,
  output logic [NSLAVE-1:0]             s_cono_clear,
  output logic [NSLAVE-1:0]             s_cono_set,
  output logic [NSLAVE-1:0]             s_iob_fm_datai,
  output logic [NSLAVE-1:0]             s_iob_fm_status,
  output logic [ios_vec_w(NSLAVE)-1:0]  s_ios,
  output logic [data_vec_w(NSLAVE)-1:0] s_iob_write,
  input  logic [pi_vec_w(NSLAVE)-1:0]   s_pi_req,
  input  logic [data_vec_w(NSLAVE)-1:0] s_iob_read,
  input  logic [NSLAVE-1:0]             s_dr_split,
  input  logic [NSLAVE-1:0]             s_rdi_data
`ifdef IOBUS_XFER_CNT_EN
  ,
  output logic [15:0]                   m_xfer_cnt
`endif
);

  logic [NSLAVE-1:0] sel;
  logic              any_sel;
  logic              xfer_strobe;
  logic              rd_strobe;

  // One comparator per slave; duplicate codes simply select several slaves
  for (genvar k = 0; k < NSLAVE; k++) begin : g_dec
    iobus_dev_decode #(
      .DEVCODE (DEVCODES[k*IOS_W +: IOS_W])
    ) u_dec (
      .m_ios_i (m_ios),
      .sel_o   (sel[k])
    );
  end

  assign any_sel     = |sel;
  assign rd_strobe   = m_iob_fm_datai | m_iob_fm_status;
  assign xfer_strobe = m_datao_set | m_cono_set | rd_strobe;

  logic [NSLAVE-1:0] s_poweron_q, s_reset_q, s_rdi_pulse_q;
  logic [NSLAVE-1:0] s_datao_clear_q, s_datao_set_q, s_cono_clear_q, s_cono_set_q;
  logic [NSLAVE-1:0] s_fm_datai_q, s_fm_status_q;
  logic [ios_vec_w(NSLAVE)-1:0]  s_ios_q;
  logic [data_vec_w(NSLAVE)-1:0] s_write_q;

  // Forward path: broadcasts copied, pulses gated by their slave select, data kept aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_poweron_q     <= '0;
      s_reset_q       <= '0;
      s_rdi_pulse_q   <= '0;
      s_datao_clear_q <= '0;
      s_datao_set_q   <= '0;
      s_cono_clear_q  <= '0;
      s_cono_set_q    <= '0;
      s_fm_datai_q    <= '0;
      s_fm_status_q   <= '0;
      s_ios_q         <= '0;
      s_write_q       <= '0;
    end else begin
      s_poweron_q     <= {NSLAVE{m_iob_poweron}};
      s_reset_q       <= {NSLAVE{m_iob_reset}};
      s_rdi_pulse_q   <= {NSLAVE{m_rdi_pulse}};
      s_datao_clear_q <= {NSLAVE{m_datao_clear}} & sel;
      s_datao_set_q   <= {NSLAVE{m_datao_set}} & sel;
      s_cono_clear_q  <= {NSLAVE{m_cono_clear}} & sel;
      s_cono_set_q    <= {NSLAVE{m_cono_set}} & sel;
      s_fm_datai_q    <= {NSLAVE{m_iob_fm_datai}} & sel;
      s_fm_status_q   <= {NSLAVE{m_iob_fm_status}} & sel;
      s_ios_q         <= {NSLAVE{m_ios}};
      s_write_q       <= {NSLAVE{m_iob_write}};
    end
  end

  logic [DATA_W-1:0] m_read_d, m_read_q;
  logic [PI_W-1:0]   m_pi_d, m_pi_q;
  logic              m_dr_split_q, m_rdi_data_q;

  // Merge trees: selected read data only during a read strobe, PI requests from every slave
  always_comb begin
    m_read_d = m_iob_write;
    m_pi_d   = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      if (rd_strobe && sel[k]) m_read_d = m_read_d | s_iob_read[k*DATA_W +: DATA_W];
      m_pi_d = m_pi_d | s_pi_req[k*PI_W +: PI_W];
    end
  end

  // Read path registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_read_q     <= '0;
      m_pi_q       <= '0;
      m_dr_split_q <= 1'b0;
      m_rdi_data_q <= 1'b0;
    end else begin
      m_read_q     <= m_read_d;
      m_pi_q       <= m_pi_d;
      m_dr_split_q <= |s_dr_split;
      m_rdi_data_q <= |s_rdi_data;
    end
  end

  nodev_state_e nodev_q;

  // Sticky absent-device flag; master IO reset clears it and wins over a new set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nodev_q <= NODEV_IDLE;
    end else begin
      case (nodev_q)
        NODEV_IDLE: if (!m_iob_reset && xfer_strobe && !any_sel) nodev_q <= NODEV_FLAG;
        NODEV_FLAG: if (m_iob_reset) nodev_q <= NODEV_IDLE;
        default:    nodev_q <= NODEV_IDLE;
      endcase
    end
  end

`ifdef IOBUS_XFER_CNT_EN
  logic        strobe_prev_q;
  logic [15:0] xfer_cnt_q;

  // Count rising edges of decoded strobes; wraps naturally, IO reset clear has priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_prev_q <= 1'b0;
      xfer_cnt_q    <= '0;
    end else begin
      strobe_prev_q <= xfer_strobe & any_sel;
      if (m_iob_reset)                                    xfer_cnt_q <= '0;
      else if (xfer_strobe && any_sel && !strobe_prev_q)  xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign m_xfer_cnt = xfer_cnt_q;
`endif

  assign s_iob_poweron   = s_poweron_q;
  assign s_iob_reset     = s_reset_q;
  assign s_rdi_pulse     = s_rdi_pulse_q;
  assign s_datao_clear   = s_datao_clear_q;
  assign s_datao_set     = s_datao_set_q;
  assign s_cono_clear    = s_cono_clear_q;
  assign s_cono_set      = s_cono_set_q;
  assign s_iob_fm_datai  = s_fm_datai_q;
  assign s_iob_fm_status = s_fm_status_q;
  assign s_ios           = s_ios_q;
  assign s_iob_write     = s_write_q;
  assign m_iob_read      = m_read_q;
  assign m_pi_req        = m_pi_q;
  assign m_dr_split      = m_dr_split_q;
  assign m_rdi_data      = m_rdi_data_q;
  assign m_nodev         = (nodev_q == NODEV_FLAG);

endmodule

// File: tb/tb_iobus_n_connect.sv
// tb/tb_iobus_n_connect.sv - scoreboard bench for iobus_n_connect (two slaves, codes 7'o070 / 7'o024)
module tb_iobus_n_connect;

  logic clk = 1'b0;
  logic reset;
  logic m_iob_poweron, m_iob_reset, m_datao_clear, m_datao_set, m_cono_clear, m_cono_set;
  logic m_iob_fm_datai, m_iob_fm_status, m_rdi_pulse;
  logic [6:0]  m_ios;
  logic [35:0] m_iob_write;
  logic [6:0]  m_pi_req;
  logic [35:0] m_iob_read;
  logic        m_dr_split, m_rdi_data, m_nodev;
  logic [1:0]  s_iob_poweron, s_iob_reset, s_rdi_pulse, s_datao_clear, s_datao_set;
  logic [1:0]  s_cono_clear, s_cono_set, s_iob_fm_datai, s_iob_fm_status;
  logic [13:0] s_ios;
  logic [71:0] s_iob_write;
  logic [13:0] s_pi_req;
  logic [71:0] s_iob_read;
  logic [1:0]  s_dr_split, s_rdi_data;
`ifdef IOBUS_XFER_CNT_EN
  logic [15:0] m_xfer_cnt;
`endif

  iobus_n_connect dut (
    .clk(clk), .reset(reset),
    .m_iob_poweron(m_iob_poweron), .m_iob_reset(m_iob_reset),
    .m_datao_clear(m_datao_clear), .m_datao_set(m_datao_set),
    .m_cono_clear(m_cono_clear), .m_cono_set(m_cono_set),
    .m_iob_fm_datai(m_iob_fm_datai), .m_iob_fm_status(m_iob_fm_status),
    .m_rdi_pulse(m_rdi_pulse), .m_ios(m_ios), .m_iob_write(m_iob_write),
    .m_pi_req(m_pi_req), .m_iob_read(m_iob_read), .m_dr_split(m_dr_split),
    .m_rdi_data(m_rdi_data), .m_nodev(m_nodev),
    .s_iob_poweron(s_iob_poweron), .s_iob_reset(s_iob_reset), .s_rdi_pulse(s_rdi_pulse),
    .s_datao_clear(s_datao_clear), .s_datao_set(s_datao_set),
    .s_cono_clear(s_cono_clear), .s_cono_set(s_cono_set),
    .s_iob_fm_datai(s_iob_fm_datai), .s_iob_fm_status(s_iob_fm_status),
    .s_ios(s_ios), .s_iob_write(s_iob_write), .s_pi_req(s_pi_req),
    .s_iob_read(s_iob_read), .s_dr_split(s_dr_split), .s_rdi_data(s_rdi_data)
`ifdef IOBUS_XFER_CNT_EN
    , .m_xfer_cnt(m_xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  pi;
    logic [35:0] rd;
    logic        dr, rdi, nodev;
    logic [1:0]  pwr, rst, rdip, dclr, dset, cclr, cset, fdi, fst;
    logic [13:0] ios;
    logic [71:0] wr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err = 0;
  logic        nodev_m;
  logic        prev_m;
  logic [15:0] cnt_m;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for the next clock given the inputs currently driven
  function automatic exp_t predict();
    exp_t e;
    logic [1:0] sel;
    logic trig, xs;
    sel[0] = (m_ios == 7'o070);
    sel[1] = (m_ios == 7'o024);
    trig = m_datao_set | m_cono_set | m_iob_fm_datai | m_iob_fm_status;
    e.rd = m_iob_write;
    if (m_iob_fm_datai | m_iob_fm_status) begin
      if (sel[0]) e.rd = e.rd | s_iob_read[35:0];
      if (sel[1]) e.rd = e.rd | s_iob_read[71:36];
    end
    e.pi   = s_pi_req[6:0] | s_pi_req[13:7];
    e.dr   = |s_dr_split;
    e.rdi  = |s_rdi_data;
    e.pwr  = {2{m_iob_poweron}};
    e.rst  = {2{m_iob_reset}};
    e.rdip = {2{m_rdi_pulse}};
    e.dclr = {2{m_datao_clear}} & sel;
    e.dset = {2{m_datao_set}} & sel;
    e.cclr = {2{m_cono_clear}} & sel;
    e.cset = {2{m_cono_set}} & sel;
    e.fdi  = {2{m_iob_fm_datai}} & sel;
    e.fst  = {2{m_iob_fm_status}} & sel;
    e.ios  = {2{m_ios}};
    e.wr   = {2{m_iob_write}};
    if (m_iob_reset) e.nodev = 1'b0;
    else if (trig && sel == 2'b00) e.nodev = 1'b1;
    else e.nodev = nodev_m;
    xs = trig & (sel != 2'b00);
    if (m_iob_reset) e.cnt = 16'd0;
    else if (xs && !prev_m) e.cnt = cnt_m + 16'd1;
    else e.cnt = cnt_m;
    nodev_m = e.nodev;
    cnt_m   = e.cnt;
    prev_m  = xs;
    return e;
  endfunction

  task automatic compare_out(input exp_t e);
    check("m_iob_read", 72'(m_iob_read), 72'(e.rd));
    check("m_pi_req", 72'(m_pi_req), 72'(e.pi));
    check("m_dr_split", 72'(m_dr_split), 72'(e.dr));
    check("m_rdi_data", 72'(m_rdi_data), 72'(e.rdi));
    check("m_nodev", 72'(m_nodev), 72'(e.nodev));
    check("s_iob_poweron", 72'(s_iob_poweron), 72'(e.pwr));
    check("s_iob_reset", 72'(s_iob_reset), 72'(e.rst));
    check("s_rdi_pulse", 72'(s_rdi_pulse), 72'(e.rdip));
    check("s_datao_clear", 72'(s_datao_clear), 72'(e.dclr));
    check("s_datao_set", 72'(s_datao_set), 72'(e.dset));
    check("s_cono_clear", 72'(s_cono_clear), 72'(e.cclr));
    check("s_cono_set", 72'(s_cono_set), 72'(e.cset));
    check("s_iob_fm_datai", 72'(s_iob_fm_datai), 72'(e.fdi));
    check("s_iob_fm_status", 72'(s_iob_fm_status), 72'(e.fst));
    check("s_ios", 72'(s_ios), 72'(e.ios));
    check("s_iob_write", s_iob_write, e.wr);
`ifdef IOBUS_XFER_CNT_EN
    check("m_xfer_cnt", 72'(m_xfer_cnt), 72'(e.cnt));
`endif
  endtask

  // Drive one clock: queue the prediction, then compare once the DUT has registered it
  task automatic step();
    sb.push_back(predict());
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("scoreboard_empty", 72'd1, 72'd0);
    else compare_out(sb.pop_front());
  endtask

  task automatic idle_inputs();
    {m_iob_poweron, m_iob_reset, m_datao_clear, m_datao_set, m_cono_clear, m_cono_set} = '0;
    {m_iob_fm_datai, m_iob_fm_status, m_rdi_pulse} = '0;
    m_ios = 7'o000; m_iob_write = '0;
    s_pi_req = '0; s_iob_read = '0; s_dr_split = '0; s_rdi_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"}, 72'(m_iob_read), 72'd0);
    check({tag, "_pi"}, 72'(m_pi_req), 72'd0);
    check({tag, "_flags"}, 72'({m_dr_split, m_rdi_data, m_nodev}), 72'd0);
    check({tag, "_s_pulses"}, 72'({s_iob_poweron, s_iob_reset, s_rdi_pulse, s_datao_clear, s_datao_set,
                                  s_cono_clear, s_cono_set, s_iob_fm_datai, s_iob_fm_status}), 72'd0);
    check({tag, "_s_ios"}, 72'(s_ios), 72'd0);
    check({tag, "_s_write"}, s_iob_write, 72'd0);
`ifdef IOBUS_XFER_CNT_EN
    check({tag, "_cnt"}, 72'(m_xfer_cnt), 72'd0);
`endif
  endtask

  task automatic model_reset();
    nodev_m = 1'b0; prev_m = 1'b0; cnt_m = '0;
    sb.delete();
  endtask

  initial begin
    logic [95:0] r;
    // 1: reset held low with every input high
    reset = 1'b0;
    {m_iob_poweron, m_iob_reset, m_datao_clear, m_datao_set, m_cono_clear, m_cono_set} = '1;
    {m_iob_fm_datai, m_iob_fm_status, m_rdi_pulse} = '1;
    m_ios = '1; m_iob_write = '1;
    s_pi_req = '1; s_iob_read = '1; s_dr_split = '1; s_rdi_data = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    idle_inputs();
    reset = 1'b1;
    m_iob_write = 36'o123456701234;
    step();

    // 2: cono_set to slave 0 only, then released
    m_ios = 7'o070; m_cono_set = 1'b1;
    step();
    m_cono_set = 1'b0;
    step();

    // 3: read from slave 1 merges with write data, slave 0 data ignored
    m_ios = 7'o024; m_iob_fm_datai = 1'b1;
    m_iob_write = 36'o100;
    s_iob_read = {36'o1, 36'o777};
    step();
    m_iob_fm_datai = 1'b0; m_iob_fm_status = 1'b1; m_ios = 7'o070;
    step();
    // read data present but no strobe: only write data returns
    m_iob_fm_status = 1'b0;
    step();
    // multi-cycle strobe with a code change mid-way
    m_iob_fm_datai = 1'b1; m_ios = 7'o024;
    step();
    m_ios = 7'o070;
    step();
    m_iob_fm_datai = 1'b0; s_iob_read = '0;

    // 4: absent device sets sticky nodev; IO reset with a new bad strobe clears it
    m_ios = 7'o077; m_datao_set = 1'b1;
    step();
    m_datao_set = 1'b0;
    step();
    step();
    m_iob_reset = 1'b1; m_cono_set = 1'b1;
    step();
    m_iob_reset = 1'b0; m_cono_set = 1'b0;
    step();

    // 5: PI request merge and other undecoded flags
    s_pi_req = {7'b1000000, 7'b0000001};
    step();
    s_pi_req = '0; s_dr_split = 2'b10; s_rdi_data = 2'b01; m_iob_poweron = 1'b1; m_rdi_pulse = 1'b1;
    step();
    idle_inputs();

    // reset mid-transfer: pulse in flight is dropped and not replayed
    m_ios = 7'o070; m_cono_set = 1'b1;
    step();
    m_ios = 7'o077; m_datao_set = 1'b1; m_cono_set = 1'b0;
    step();
    m_ios = 7'o024; m_datao_set = 1'b1;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    check("midreset_hold", 72'(s_datao_set), 72'd0);
    idle_inputs();
    model_reset();
    reset = 1'b1;
    step();

    // random traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: m_ios = 7'o070;
        1: m_ios = 7'o024;
        2: m_ios = 7'o077;
        default: m_ios = 7'($urandom());
      endcase
      m_iob_poweron   = 1'($urandom());
      m_iob_reset     = ($urandom_range(0, 7) == 0);
      m_datao_clear   = 1'($urandom());
      m_datao_set     = 1'($urandom());
      m_cono_clear    = 1'($urandom());
      m_cono_set      = 1'($urandom());
      m_iob_fm_datai  = 1'($urandom());
      m_iob_fm_status = 1'($urandom());
      m_rdi_pulse     = 1'($urandom());
      r = {$urandom(), $urandom(), $urandom()};
      m_iob_write = r[35:0];
      r = {$urandom(), $urandom(), $urandom()};
      s_iob_read = r[71:0];
      s_pi_req   = 14'($urandom());
      s_dr_split = 2'($urandom());
      s_rdi_data = 2'($urandom());
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
